// File: rtl/kbd_pkg.sv
// Shared set-2 scan-code constants, key encoding and parser state encoding
// for the multi-key tracker and its key table.
package kbd_pkg;

  localparam int KEY_W = 9;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ERR   = 8'hFC;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;

  // Bytes that follow E1 in a Pause sequence.
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } parse_st_e;

  // Self-test / overrun bytes that carry no key information.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ERR) || (b == SC_OVR0) || (b == SC_OVR1);
  endfunction

endpackage

// File: rtl/kbd_key_table.sv
// Held-key slot table: match, lowest-free-slot insert, clear on break.
// Lookup is combinational; insert/clear take effect on the next rising edge.
module kbd_key_table
  import kbd_pkg::*;
#(
  parameter int MAX_KEYS = 4
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [KEY_W-1:0]          look_code,
  input  logic                      ins_en,
  input  logic                      del_en,
  output logic                      hit,
  output logic                      full,
  output logic [MAX_KEYS-1:0]       valid,
  output logic [KEY_W*MAX_KEYS-1:0] codes
);

  logic [MAX_KEYS-1:0] valid_q, valid_d;
  logic [KEY_W-1:0]    code_q [MAX_KEYS];
  logic [KEY_W-1:0]    code_d [MAX_KEYS];
  logic [MAX_KEYS-1:0] hit_vec;
  logic [MAX_KEYS-1:0] free_vec;
  logic                free_found;

  always_comb begin
    hit_vec    = '0;
    free_vec   = '0;
    free_found = 1'b0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      hit_vec[i] = valid_q[i] && (code_q[i] == look_code);
      if (!valid_q[i] && !free_found) begin
        free_vec[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  assign hit  = |hit_vec;
  assign full = &valid_q;

  // Slots never shift: insert fills one free slot, clear empties one matched slot.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < MAX_KEYS; i++) begin
      code_d[i] = code_q[i];
      if (ins_en && free_vec[i]) begin
        valid_d[i] = 1'b1;
        code_d[i]  = look_code;
      end
      if (del_en && hit_vec[i]) begin
        valid_d[i] = 1'b0;
        code_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      for (int i = 0; i < MAX_KEYS; i++) code_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < MAX_KEYS; i++) code_q[i] <= code_d[i];
    end
  end

  assign valid = valid_q;

  for (genvar g = 0; g < MAX_KEYS; g++) begin : g_flat
    assign codes[KEY_W*g +: KEY_W] = code_q[g];
  end

endmodule

// File: rtl/kbd_multi_tracker.sv
// Set-2 scan-code parser feeding a multi-key table with holdoff and repeat filtering.
// One byte consumed per two cycles at most; events valid the cycle after the consume.
module kbd_multi_tracker
  import kbd_pkg::*;
#(
  parameter int MAX_KEYS  = 4,
  parameter int HOLDOFF   = 5000000,
  parameter int REPEAT_EN = 0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [7:0]                data,
  input  logic                      ready,
  output logic                      nextdata_n,
  output logic [MAX_KEYS-1:0]       key_valid,
  output logic [KEY_W*MAX_KEYS-1:0] key_codes,
  output logic [KEY_W-1:0]          key_last,
  output logic                      ev_valid,
  output logic [KEY_W-1:0]          ev_code,
  output logic                      ev_make,
  output logic                      ev_rep,
  output logic                      full_err
);

  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);

  parse_st_e        state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [KEY_W-1:0] key_last_q, key_last_d;
  logic             ev_valid_q, ev_valid_d;
  logic [KEY_W-1:0] ev_code_q, ev_code_d;
  logic             ev_make_q, ev_make_d;
  logic             ev_rep_q, ev_rep_d;
  logic             full_err_q, full_err_d;
  logic [KEY_W-1:0] ho_code_q, ho_code_d;
  logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;

  logic             consume;
  logic             make_req, brk_req;
  logic [KEY_W-1:0] req_code;
  logic             tbl_hit, tbl_full, ins_en, del_en, ho_block;

  assign consume      = ready && nextdata_n_q;
  assign nextdata_n_d = !consume;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    make_req = 1'b0;
    brk_req  = 1'b0;
    req_code = '0;
    if (consume) begin
      case (state_q)
        ST_IDLE: begin
          if (data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (data == SC_BRK) begin
            state_d = ST_BRK;
          end else if (data == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LEN;
          end else if (!is_status_byte(data)) begin
            make_req = 1'b1;
            req_code = {1'b0, data};
          end
        end
        ST_EXT: begin
          if (data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            make_req = 1'b1;
            req_code = {1'b1, data};
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_req  = 1'b1;
          req_code = {1'b0, data};
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_req  = 1'b1;
          req_code = {1'b1, data};
          state_d  = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pre-edge counter value decides, so a make landing on the expiry cycle is still blocked.
  assign ho_block = (ho_code_q == req_code) && (ho_cnt_q != '0);

  always_comb begin
    ins_en     = 1'b0;
    del_en     = 1'b0;
    key_last_d = key_last_q;
    ev_valid_d = 1'b0;
    ev_code_d  = ev_code_q;
    ev_make_d  = ev_make_q;
    ev_rep_d   = ev_rep_q;
    full_err_d = full_err_q;
    ho_code_d  = ho_code_q;
    ho_cnt_d   = (ho_cnt_q != '0) ? ho_cnt_q - 1'b1 : ho_cnt_q;
    if (make_req) begin
      if (tbl_hit) begin
        if (REPEAT_EN != 0) begin
          ev_valid_d = 1'b1;
          ev_code_d  = req_code;
          ev_make_d  = 1'b1;
          ev_rep_d   = 1'b1;
        end
      end else if (ho_block) begin
        ev_valid_d = 1'b0;
      end else if (tbl_full) begin
        full_err_d = 1'b1;
      end else begin
        ins_en     = 1'b1;
        key_last_d = req_code;
        ev_valid_d = 1'b1;
        ev_code_d  = req_code;
        ev_make_d  = 1'b1;
        ev_rep_d   = 1'b0;
      end
    end else if (brk_req && tbl_hit) begin
      del_en     = 1'b1;
      ev_valid_d = 1'b1;
      ev_code_d  = req_code;
      ev_make_d  = 1'b0;
      ev_rep_d   = 1'b0;
      ho_code_d  = req_code;
      ho_cnt_d   = HO_LOAD;
      if (key_last_q == req_code) key_last_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      skip_q       <= '0;
      nextdata_n_q <= 1'b1;
      key_last_q   <= '0;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= '0;
      ev_make_q    <= 1'b0;
      ev_rep_q     <= 1'b0;
      full_err_q   <= 1'b0;
      ho_code_q    <= '0;
      ho_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      nextdata_n_q <= nextdata_n_d;
      key_last_q   <= key_last_d;
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_make_q    <= ev_make_d;
      ev_rep_q     <= ev_rep_d;
      full_err_q   <= full_err_d;
      ho_code_q    <= ho_code_d;
      ho_cnt_q     <= ho_cnt_d;
    end
  end

  kbd_key_table #(.MAX_KEYS(MAX_KEYS)) u_table (
    .clk       (clk),
    .clr       (clr),
    .look_code (req_code),
    .ins_en    (ins_en),
    .del_en    (del_en),
    .hit       (tbl_hit),
    .full      (tbl_full),
    .valid     (key_valid),
    .codes     (key_codes)
  );

  assign nextdata_n = nextdata_n_q;
  assign key_last   = key_last_q;
  assign ev_valid   = ev_valid_q;
  assign ev_code    = ev_code_q;
  assign ev_make    = ev_make_q;
  assign ev_rep     = ev_rep_q;
  assign full_err   = full_err_q;

endmodule

// File: tb/tb_kbd_multi_tracker.sv
// Drives two tracker instances (2-slot no-repeat, 4-slot repeat) with one byte stream
// and checks event queues plus table state at directed points.
module tb_kbd_multi_tracker;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] data;
  logic       ready;

  logic        nextdata_n0, ev_valid0, ev_make0, ev_rep0, full_err0;
  logic [1:0]  key_valid0;
  logic [17:0] key_codes0;
  logic [8:0]  key_last0, ev_code0;

  logic        nextdata_n1, ev_valid1, ev_make1, ev_rep1, full_err1;
  logic [3:0]  key_valid1;
  logic [35:0] key_codes1;
  logic [8:0]  key_last1, ev_code1;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;
  int s0;
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic [10:0] exp0, exp1;

  always #5 clk = ~clk;

  kbd_multi_tracker #(.MAX_KEYS(2), .HOLDOFF(100), .REPEAT_EN(0)) dut0 (
    .clk(clk), .clr(clr), .data(data), .ready(ready), .nextdata_n(nextdata_n0),
    .key_valid(key_valid0), .key_codes(key_codes0), .key_last(key_last0),
    .ev_valid(ev_valid0), .ev_code(ev_code0), .ev_make(ev_make0), .ev_rep(ev_rep0),
    .full_err(full_err0)
  );

  kbd_multi_tracker #(.MAX_KEYS(4), .HOLDOFF(100), .REPEAT_EN(1)) dut1 (
    .clk(clk), .clr(clr), .data(data), .ready(ready), .nextdata_n(nextdata_n1),
    .key_valid(key_valid1), .key_codes(key_codes1), .key_last(key_last1),
    .ev_valid(ev_valid1), .ev_code(ev_code1), .ev_make(ev_make1), .ev_rep(ev_rep1),
    .full_err(full_err1)
  );

  always @(posedge clk) if (nextdata_n0 === 1'b0) low_cnt <= low_cnt + 1;

  always @(negedge clk) begin
    if (!clr && ev_valid0 === 1'b1) begin
      checks++;
      assert (q0.size() != 0) else begin
        errors++;
        $error("FAIL ev0_unexpected observed=%h expected=none", {ev_code0, ev_make0, ev_rep0});
      end
      if (q0.size() != 0) begin
        exp0 = q0.pop_front();
        checks++;
        assert ({ev_code0, ev_make0, ev_rep0} === exp0) else begin
          errors++;
          $error("FAIL ev0 observed=%h expected=%h", {ev_code0, ev_make0, ev_rep0}, exp0);
        end
      end
    end
    if (!clr && ev_valid1 === 1'b1) begin
      checks++;
      assert (q1.size() != 0) else begin
        errors++;
        $error("FAIL ev1_unexpected observed=%h expected=none", {ev_code1, ev_make1, ev_rep1});
      end
      if (q1.size() != 0) begin
        exp1 = q1.pop_front();
        checks++;
        assert ({ev_code1, ev_make1, ev_rep1} === exp1) else begin
          errors++;
          $error("FAIL ev1 observed=%h expected=%h", {ev_code1, ev_make1, ev_rep1}, exp1);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input bit to0, input bit to1, input logic [8:0] code,
                           input bit mk, input bit rp);
    if (to0) q0.push_back({code, mk, rp});
    if (to1) q1.push_back({code, mk, rp});
  endtask

  // Offer a byte; return at the negedge where both DUTs show the pop pulse.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n;
    data  = b;
    ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ({nextdata_n0, nextdata_n1} !== 2'b00 && n < 20);
    check("consume_pulse", {nextdata_n0, nextdata_n1}, 2'b00);
    if (!hold) ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ready = 1'b0;
    clr   = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
  endtask

  initial begin
    clr   = 1'b1;
    ready = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    clr = 1'b0;

    check("rst_nextdata", {nextdata_n0, nextdata_n1}, 2'b11);
    check("rst_valid", {key_valid0, key_valid1}, 6'h0);
    check("rst_codes0", key_codes0, 18'h0);
    check("rst_codes1", key_codes1, 36'h0);
    check("rst_last", {key_last0, key_last1}, 18'h0);
    check("rst_ev0", {ev_valid0, ev_code0, ev_make0, ev_rep0}, 12'h0);
    check("rst_ev1", {ev_valid1, ev_code1, ev_make1, ev_rep1}, 12'h0);
    check("rst_full", {full_err0, full_err1}, 2'b00);

    // Two makes then two breaks
    expect_ev(1, 1, 9'h01C, 1, 0); send_byte(8'h1C, 0);
    expect_ev(1, 1, 9'h01B, 1, 0); send_byte(8'h1B, 0);
    check("a_valid0", key_valid0, 2'b11);
    check("a_codes0", key_codes0, {9'h01B, 9'h01C});
    check("a_valid1", key_valid1, 4'b0011);
    check("a_codes1", key_codes1, {9'h000, 9'h000, 9'h01B, 9'h01C});
    check("a_last", {key_last0, key_last1}, {9'h01B, 9'h01B});
    expect_ev(1, 1, 9'h01C, 0, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    check("a_last_kept", key_last0, 9'h01B);
    expect_ev(1, 1, 9'h01B, 0, 0); send_byte(8'hF0, 0); send_byte(8'h1B, 0);
    check("a_empty", {key_valid0, key_valid1}, 6'h0);
    check("a_codes_clr", {key_codes0, key_codes1}, 54'h0);
    check("a_last_clr", {key_last0, key_last1}, 18'h0);

    // Extended make/break
    expect_ev(1, 1, 9'h175, 1, 0); send_byte(8'hE0, 0); send_byte(8'h75, 0);
    check("b_last", {key_last0, key_last1}, {9'h175, 9'h175});
    check("b_codes0", key_codes0, {9'h000, 9'h175});
    expect_ev(1, 1, 9'h175, 0, 0);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    check("b_last_clr", {key_last0, key_last1}, 18'h0);
    check("b_empty", {key_valid0, key_valid1}, 6'h0);

    // Release-bounce holdoff
    pulse_clr();
    expect_ev(1, 1, 9'h01C, 1, 0); send_byte(8'h1C, 0);
    expect_ev(1, 1, 9'h01C, 0, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    repeat (47) @(negedge clk);
    send_byte(8'h1C, 0);
    check("h_blocked", {key_valid0, key_valid1}, 6'h0);
    repeat (100) @(negedge clk);
    expect_ev(1, 1, 9'h01C, 1, 0); send_byte(8'h1C, 0);
    check("h_expired", {key_valid0, key_valid1}, {2'b01, 4'b0001});

    // Table full on the 2-slot instance
    pulse_clr();
    check("f_clr_full", {full_err0, full_err1}, 2'b00);
    expect_ev(1, 1, 9'h01C, 1, 0); send_byte(8'h1C, 0);
    expect_ev(1, 1, 9'h01B, 1, 0); send_byte(8'h1B, 0);
    expect_ev(0, 1, 9'h023, 1, 0); send_byte(8'h23, 0);
    check("f_full_err", {full_err0, full_err1}, 2'b10);
    check("f_valid", {key_valid0, key_valid1}, {2'b11, 4'b0111});
    check("f_last0", key_last0, 9'h01B);
    expect_ev(1, 1, 9'h01C, 0, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    expect_ev(1, 0, 9'h023, 1, 0); expect_ev(0, 1, 9'h023, 1, 1); send_byte(8'h23, 0);
    check("f_codes0", key_codes0, {9'h01B, 9'h023});
    check("f_codes1", key_codes1, {9'h000, 9'h023, 9'h01B, 9'h000});
    check("f_valid1", key_valid1, 4'b0110);
    check("f_last", {key_last0, key_last1}, {9'h023, 9'h023});
    check("f_sticky", full_err0, 1'b1);

    // Typematic repeats
    pulse_clr();
    expect_ev(1, 1, 9'h01C, 1, 0); send_byte(8'h1C, 0);
    expect_ev(0, 1, 9'h01C, 1, 1); send_byte(8'h1C, 0);
    expect_ev(0, 1, 9'h01C, 1, 1); send_byte(8'h1C, 0);
    check("r_valid", {key_valid0, key_valid1}, {2'b01, 4'b0001});

    // Reset in the middle of E0 F0
    pulse_clr();
    send_byte(8'hE0, 0); send_byte(8'hF0, 0);
    pulse_clr();
    expect_ev(1, 1, 9'h01C, 1, 0); send_byte(8'h1C, 0);
    check("m_codes0", key_codes0, {9'h000, 9'h01C});
    check("m_codes1", key_codes1, {9'h000, 9'h000, 9'h000, 9'h01C});

    // Pause sequence with ready held high
    pulse_clr();
    repeat (3) @(negedge clk);
    s0 = low_cnt;
    expect_ev(1, 1, 9'h01C, 1, 0);
    send_byte(8'hE1, 1); send_byte(8'h14, 1); send_byte(8'h77, 1); send_byte(8'hE1, 1);
    send_byte(8'hF0, 1); send_byte(8'h14, 1); send_byte(8'hF0, 1); send_byte(8'h77, 1);
    send_byte(8'h1C, 0);
    check("p_codes0", key_codes0, {9'h000, 9'h01C});
    check("p_valid", {key_valid0, key_valid1}, {2'b01, 4'b0001});
    repeat (3) @(negedge clk);
    check("p_pulses", low_cnt - s0, 9);

    repeat (5) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_multi_tracker.md
# kbd_multi_tracker

Parametrised PS/2 scan-code tracker that consumes set-2 bytes from `ps2_keyboard` and keeps a table of up to `MAX_KEYS` simultaneously held keys. It handles `E0` extended prefixes and `F0` break codes, and discards `E1` Pause sequences. It suppresses typematic repeats and per-key release bounce, and emits one-cycle make/break events. It replaces the single-key output stage between `ps2_keyboard` and the consumers (tone generator, display).

## Interface
- `MAX_KEYS`, default 4: number of held-key slots (1..8).
- `HOLDOFF`, default 5000000: clock cycles during which a make of a just-released code is ignored.
- `REPEAT_EN`, default 0: 1 = typematic repeats of held keys produce events flagged `ev_rep`.
- `clk` input 1: system clock; all logic on rising edge.
- `clr` input 1: reset, synchronous, active-high.
- `data` input 8: byte from `ps2_keyboard`.
- `ready` input 1: byte available in `ps2_keyboard` FIFO.
- `nextdata_n` output 1: low for one cycle to pop the FIFO.
- `key_valid` output `MAX_KEYS`: slot i holds a key.
- `key_codes` output `9*MAX_KEYS`: slot i at `[9i+8:9i]` = {ext, code}.
- `key_last` output 9: most recently made key still held; 0 if none.
- `ev_valid` output 1: one-cycle event strobe.
- `ev_code` output 9: {ext, code} of the event.
- `ev_make` output 1: 1 = make, 0 = break.
- `ev_rep` output 1: event is a typematic repeat.
- `full_err` output 1: sticky; a make was dropped because the table was full. Cleared only by `clr`.

## Operation
- Consume rule: a byte is consumed in a cycle where `ready=1` and `nextdata_n=1`. `nextdata_n` is registered: 0 in the cycle after a consume, otherwise 1. This gives at most one consume per two cycles and no double-read.
- Parser FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`), SKIP (Pause).
  - IDLE: `E0`→EXT, `F0`→BRK, `E1`→SKIP with skip counter=7. `AA`/`FC`/`00`/`FF` are ignored and stay in IDLE. Any other byte is a make of {0,byte}.
  - EXT: `F0`→EXT_BRK. Any other byte is a make of {1,byte} and returns to IDLE; this includes `E0`, which is taken as a code.
  - BRK: any byte is a break of {0,byte} → IDLE.
  - EXT_BRK: any byte is a break of {1,byte} → IDLE.
  - SKIP: decrement the counter on each consumed byte; return to IDLE on the consume where the counter reaches 0. No events are produced.
- Make handling:
  - Code already in the table: repeat. Emits an event with `ev_rep=1` only if `REPEAT_EN`; the table is unchanged.
  - Code matches the holdoff register with a nonzero counter: ignored entirely.
  - Otherwise the code is inserted into the lowest-index free slot, becomes `key_last`, and an event is emitted.
  - Table full: the make is dropped, `full_err` is set, no event.
- Break handling:
  - Matching slot: cleared, break event emitted. The code is loaded into the holdoff register and the counter is loaded with `HOLDOFF`. If the broken key was `key_last`, `key_last` becomes 0.
  - No matching slot: ignored, no event.
- Holdoff counter: one counter with one code register. It decrements to 0 every cycle. A new break reloads both the code and the counter.
- Slot order is stable: remaining slots never shift.

## Timing
- Table, `key_last`, and event outputs update on the edge that ends the consume cycle. Events are valid the following cycle, for exactly one cycle.
- Values after `clr`: `nextdata_n=1`, FSM=IDLE, all `key_valid=0`, `key_codes=0`, `key_last=0`, `ev_valid=0`, `ev_code=0`, `ev_make=0`, `ev_rep=0`, `full_err=0`, holdoff counter=0.
- `clr` asserted mid-sequence (for example after `E0 F0`) drops the partial sequence. The next byte is parsed from IDLE.
- Holdoff expiry and a make consumed in the same cycle: the counter value before the edge decides. Nonzero means the make is ignored.

## Structure
- Shared package `kbd_pkg` holds the scan-code constants (`SC_EXT=E0`, `SC_BRK=F0`, `SC_PAUSE=E1`, `SC_BAT=AA`), the parser state encoding, and the `E1` skip length 7.
- Natural sub-module: `kbd_key_table`. It holds the slot storage, match, free-slot priority encoder, insert and clear logic. The parser FSM, handshake, and holdoff logic stay in the top module.

## Test plan
- Bytes `1C`, `1B`, `F0 1C`, `F0 1B`: events make 01C, make 01B, break 01C, break 01B. After the 2nd byte, slots 0/1 = 01C/01B. After the last byte, all slots are empty.
- `E0 75`, `E0 F0 75`: make 175, then break 175. `key_last` is 175 after the make, then 0.
- `HOLDOFF=100`. Sequence `1C`, `F0 1C`, then `1C` 50 cycles later: no event. Another `1C` 150 cycles after the break: make 01C.
- `MAX_KEYS=2`. Makes `1C`, `1B`, `23`: third is dropped, `full_err=1`. Then `F0 1C`, `23`: 023 goes into slot 0.
- `1C` ×3 with `REPEAT_EN=0`: one event. With `REPEAT_EN=1`: three events, the last two with `ev_rep=1`.
- `E1 14 77 E1 F0 14 F0 77`, then `1C`: no events for the 8 Pause bytes, then make 01C. With `ready` held high, `nextdata_n` pulses low once per byte.
